dm_bus_arbiter: RTL

DM_BUS_ARBITER -- requirements
Module: dm_bus_arbiter

---
 rtl/dm_bus_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dm_bus_arbiter.sv
// Arbitrates NrPorts requesters onto one system bus master port, one transaction in flight.
// Define DM_BUS_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (port 0 highest).
//
// state  | meaning
// IDLE   | no transaction; arbitrate and latch the winner as owner
// REQ    | owner's request presented on the master port, waiting for grant
// WAIT_R | granted, waiting for the response
module dm_bus_arbiter #(
  parameter int unsigned NrPorts  = 2,
  parameter int unsigned BusWidth = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NrPorts-1:0]                    req_i,
  input  logic [NrPorts-1:0][BusWidth-1:0]      add_i,
  input  logic [NrPorts-1:0]                    we_i,
  input  logic [NrPorts-1:0][BusWidth-1:0]      wdata_i,
  input  logic [NrPorts-1:0][BusWidth/8-1:0]    be_i,
  output logic [NrPorts-1:0]                    gnt_o,
  output logic [NrPorts-1:0]                    r_valid_o,
  output logic [BusWidth-1:0]                   r_rdata_o,
  output logic                                  master_req_o,
  output logic [BusWidth-1:0]                   master_add_o,
  output logic                                  master_we_o,
  output logic [BusWidth-1:0]                   master_wdata_o,
  output logic [BusWidth/8-1:0]                 master_be_o,
  input  logic                                  master_gnt_i,
  input  logic                                  master_r_valid_i,
  input  logic [BusWidth-1:0]                   master_r_rdata_i,
  output logic                                  busy_o
);

  localparam int unsigned OwnerW = $clog2(NrPorts);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] WAIT_R = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [OwnerW-1:0] owner_q, owner_d;
  logic [OwnerW-1:0] winner;
  logic              owner_req;
  logic              owner_gnt;
  logic              owner_rsp;

  assign owner_req = req_i[owner_q];
  assign owner_gnt = master_req_o & master_gnt_i;
  assign owner_rsp = (state_q == WAIT_R) & master_r_valid_i;

`ifdef DM_BUS_ARBITER_ROUND_ROBIN_EN
  logic [OwnerW-1:0] ptr_q, ptr_d;
  logic              rr_found;
  int unsigned       rr_idx;

  // Scan from the pointer upwards, wrapping at NrPorts; first requester wins.
  always_comb begin
    winner   = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int unsigned i = 0; i < NrPorts; i++) begin
      rr_idx = 32'(ptr_q) + i;
      if (rr_idx >= NrPorts) rr_idx = rr_idx - NrPorts;
      if (!rr_found && req_i[OwnerW'(rr_idx)]) begin
        rr_found = 1'b1;
        winner   = OwnerW'(rr_idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (owner_gnt) begin
      if (owner_q == OwnerW'(NrPorts - 1)) ptr_d = '0;
      else                                 ptr_d = owner_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  // Descending scan so the lowest requesting index is the last assignment.
  always_comb begin
    winner = '0;
    for (int i = int'(NrPorts) - 1; i >= 0; i--) begin
      if (req_i[i]) winner = OwnerW'(i);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          owner_d = winner;
          state_d = REQ;
        end
      end
      REQ: begin
        if (!owner_req)        state_d = IDLE;
        else if (master_gnt_i) state_d = WAIT_R;
      end
      WAIT_R: begin
        if (master_r_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  assign master_req_o = (state_q == REQ) & owner_req;

  // Master fields are forced to zero whenever no request is presented.
  always_comb begin
    master_add_o   = '0;
    master_we_o    = 1'b0;
    master_wdata_o = '0;
    master_be_o    = '0;
    if (master_req_o) begin
      master_add_o   = add_i[owner_q];
      master_we_o    = we_i[owner_q];
      master_wdata_o = wdata_i[owner_q];
      master_be_o    = be_i[owner_q];
    end
  end

  always_comb begin
    gnt_o     = '0;
    r_valid_o = '0;
    if (owner_gnt) gnt_o[owner_q]     = 1'b1;
    if (owner_rsp) r_valid_o[owner_q] = 1'b1;
  end

  assign r_rdata_o = master_r_rdata_i;
  assign busy_o    = (state_q != IDLE);

endmodule
